// File: rtl/mem_bus_scheduler.sv
// -----------------------------------------------------------------------------
// mem_bus_scheduler
//
// Sequences all traffic on the 64-bit tagged processor/memory bus for the
// negator datapath. Load and store requests arrive over valid/ready
// handshakes. At most one bus command is issued per cycle. The block tracks
// outstanding transactions by tag, replays commands the memory rejects, and
// routes each tagged response back as load data or as a store completion.
//
// Handshake semantics (both request ports):
//   A request transfers in a cycle where valid && ready are both high at the
//   rising edge. The requester must not make valid depend on ready. Ready is
//   combinational from the request valids, mem2proc_response and the
//   outstanding-table state. At most one of ld_req_ready / st_req_ready is
//   high in any cycle. An accepted request is on the bus the next cycle.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   ld_req_*              load request (valid, addr) / ready
//   st_req_*              store request (valid, addr, data) / ready
//   ld_resp_*             one-cycle load return pulse with addr and data
//   st_done               one-cycle store completion pulse
//   proc2mem_*            registered bus command / address / data
//   mem2proc_response     0 = reject, else tag assigned to this cycle's command
//   mem2proc_tag/_data    0 = no completion, else tag completing (with data)
//   err                   sticky protocol error flag, cleared only by reset
// -----------------------------------------------------------------------------
module mem_bus_scheduler #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TAG_W   = 4,
  parameter int MAX_OUT = 4,
  parameter int STARVE  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ld_req_valid,
  input  logic [ADDR_W-1:0] ld_req_addr,
  output logic              ld_req_ready,
  input  logic              st_req_valid,
  input  logic [ADDR_W-1:0] st_req_addr,
  input  logic [DATA_W-1:0] st_req_data,
  output logic              st_req_ready,
  output logic              ld_resp_valid,
  output logic [ADDR_W-1:0] ld_resp_addr,
  output logic [DATA_W-1:0] ld_resp_data,
  output logic              st_done,
  output logic [1:0]        proc2mem_command,
  output logic [ADDR_W-1:0] proc2mem_address,
  output logic [DATA_W-1:0] proc2mem_data,
  input  logic [TAG_W-1:0]  mem2proc_response,
  input  logic [DATA_W-1:0] mem2proc_data,
  input  logic [TAG_W-1:0]  mem2proc_tag,
  output logic              err
);

  localparam logic [1:0] CMD_NONE  = 2'd0;
  localparam logic [1:0] CMD_LOAD  = 2'd1;
  localparam logic [1:0] CMD_STORE = 2'd2;

  localparam int IDX_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  // Wide enough to hold MAX_OUT + 1 without wrapping.
  localparam int CNT_W = $clog2(MAX_OUT + 1) + 1;
  localparam int STK_W = (STARVE > 1) ? $clog2(STARVE) : 1;

  localparam logic [CNT_W-1:0] MAX_OUT_C  = CNT_W'(MAX_OUT);
  localparam logic [STK_W-1:0] STREAK_MAX = STK_W'(STARVE - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]        r_cmd;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;

  logic [MAX_OUT-1:0] r_tab_valid;
  logic [MAX_OUT-1:0] r_tab_load;
  logic [TAG_W-1:0]   r_tab_tag  [MAX_OUT];
  logic [ADDR_W-1:0]  r_tab_addr [MAX_OUT];

  logic [STK_W-1:0]  r_streak;

  logic              r_ld_resp_valid;
  logic [ADDR_W-1:0] r_ld_resp_addr;
  logic [DATA_W-1:0] r_ld_resp_data;
  logic              r_st_done;
  logic              r_err;

  // ---------------------------------------------------------------------------
  // Bus slot status
  // ---------------------------------------------------------------------------
  logic w_bus_busy;
  logic w_resp_nz;
  logic w_bus_accept;
  logic w_slot_free;

  assign w_bus_busy   = (r_cmd != CMD_NONE);
  assign w_resp_nz    = (mem2proc_response != '0);
  assign w_bus_accept = w_bus_busy && w_resp_nz;
  // The bus registers may be reloaded when idle or when the current command
  // is taken this cycle; otherwise the command is held and replayed.
  assign w_slot_free  = !w_bus_busy || w_resp_nz;

  // ---------------------------------------------------------------------------
  // Retirement lookup: which valid entry (if any) does mem2proc_tag complete
  // ---------------------------------------------------------------------------
  logic             w_ret_hit;
  logic [IDX_W-1:0] w_ret_idx;
  logic             w_ret_miss;
  logic             w_ret_is_load;
  logic [ADDR_W-1:0] w_ret_addr;

  always_comb begin
    w_ret_hit = 1'b0;
    w_ret_idx = '0;
    // Descending scan so the lowest matching index wins.
    for (int i = MAX_OUT - 1; i >= 0; i--) begin
      if (r_tab_valid[i] && (mem2proc_tag != '0) && (r_tab_tag[i] == mem2proc_tag)) begin
        w_ret_hit = 1'b1;
        w_ret_idx = IDX_W'(i);
      end
    end
  end

  assign w_ret_miss    = (mem2proc_tag != '0) && !w_ret_hit;
  assign w_ret_is_load = r_tab_load[w_ret_idx];
  assign w_ret_addr    = r_tab_addr[w_ret_idx];

  // ---------------------------------------------------------------------------
  // Insertion checks. Retirement is processed first, so an entry retiring this
  // cycle counts as free and its tag may be reassigned in the same cycle.
  // ---------------------------------------------------------------------------
  logic             w_dup_hit;
  logic             w_dup;
  logic             w_free_found;
  logic [IDX_W-1:0] w_free_idx;
  logic             w_insert;
  logic             w_overflow;

  always_comb begin
    w_dup_hit = 1'b0;
    for (int i = 0; i < MAX_OUT; i++) begin
      if (r_tab_valid[i] && (r_tab_tag[i] == mem2proc_response) &&
          !(w_ret_hit && (w_ret_idx == IDX_W'(i)))) begin
        w_dup_hit = 1'b1;
      end
    end
  end

  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int i = MAX_OUT - 1; i >= 0; i--) begin
      if (!r_tab_valid[i] || (w_ret_hit && (w_ret_idx == IDX_W'(i)))) begin
        w_free_found = 1'b1;
        w_free_idx   = IDX_W'(i);
      end
    end
  end

  assign w_dup      = w_bus_accept && w_dup_hit;
  assign w_insert   = w_bus_accept && !w_dup && w_free_found;
  // Capacity gating keeps this unreachable; it is flagged rather than dropped
  // silently in case the memory misbehaves.
  assign w_overflow = w_bus_accept && !w_dup && !w_free_found;

  // ---------------------------------------------------------------------------
  // Occupancy and grant
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] w_count;
  logic [CNT_W-1:0] w_cnt_plus;
  logic             w_can_grant;
  logic             w_ld_priority;
  logic             w_st_grant;
  logic             w_ld_grant;

  always_comb begin
    w_count = '0;
    for (int i = 0; i < MAX_OUT; i++) begin
      w_count = w_count + CNT_W'(r_tab_valid[i]);
    end
  end

  // A command accepted this cycle occupies an entry from the next cycle on;
  // a same-cycle retirement is deliberately not credited.
  assign w_cnt_plus    = w_count + CNT_W'(w_bus_accept);
  assign w_can_grant   = !reset && w_slot_free && (w_cnt_plus < MAX_OUT_C);
  // Once stores have won STARVE-1 times in a row over a waiting load, the
  // load takes the next grant.
  assign w_ld_priority = ld_req_valid && (r_streak == STREAK_MAX);
  assign w_st_grant    = w_can_grant && st_req_valid && !w_ld_priority;
  assign w_ld_grant    = w_can_grant && ld_req_valid && !w_st_grant;

  assign st_req_ready = w_st_grant;
  assign ld_req_ready = w_ld_grant;

  // ---------------------------------------------------------------------------
  // Sequential update
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cmd           <= CMD_NONE;
      r_addr          <= '0;
      r_data          <= '0;
      r_tab_valid     <= '0;
      r_tab_load      <= '0;
      for (int i = 0; i < MAX_OUT; i++) begin
        r_tab_tag[i]  <= '0;
        r_tab_addr[i] <= '0;
      end
      r_streak        <= '0;
      r_ld_resp_valid <= 1'b0;
      r_ld_resp_addr  <= '0;
      r_ld_resp_data  <= '0;
      r_st_done       <= 1'b0;
      r_err           <= 1'b0;
    end else begin
      // Bus registers: reload when the slot frees, otherwise hold for replay.
      if (w_slot_free) begin
        if (w_st_grant) begin
          r_cmd  <= CMD_STORE;
          r_addr <= st_req_addr;
          r_data <= st_req_data;
        end else if (w_ld_grant) begin
          r_cmd  <= CMD_LOAD;
          r_addr <= ld_req_addr;
          r_data <= '0;
        end else begin
          r_cmd  <= CMD_NONE;
          r_addr <= '0;
          r_data <= '0;
        end
      end

      // Streak of store grants made while a load was waiting.
      if (!ld_req_valid || w_ld_grant) begin
        r_streak <= '0;
      end else if (w_st_grant && (r_streak != STREAK_MAX)) begin
        r_streak <= r_streak + 1'b1;
      end

      // Outstanding table: retire first, then insert. When both hit the same
      // index the later insertion assignment takes effect.
      if (w_ret_hit) begin
        r_tab_valid[w_ret_idx] <= 1'b0;
      end
      if (w_insert) begin
        r_tab_valid[w_free_idx] <= 1'b1;
        r_tab_load[w_free_idx]  <= (r_cmd == CMD_LOAD);
        r_tab_tag[w_free_idx]   <= mem2proc_response;
        r_tab_addr[w_free_idx]  <= r_addr;
      end

      // Completion routing, one cycle after the tag arrives.
      r_ld_resp_valid <= w_ret_hit && w_ret_is_load;
      r_ld_resp_addr  <= (w_ret_hit && w_ret_is_load) ? w_ret_addr : '0;
      r_ld_resp_data  <= (w_ret_hit && w_ret_is_load) ? mem2proc_data : '0;
      r_st_done       <= w_ret_hit && !w_ret_is_load;

      if (w_ret_miss || w_dup || w_overflow) begin
        r_err <= 1'b1;
      end
    end
  end

  assign proc2mem_command = r_cmd;
  assign proc2mem_address = r_addr;
  assign proc2mem_data    = r_data;
  assign ld_resp_valid    = r_ld_resp_valid;
  assign ld_resp_addr     = r_ld_resp_addr;
  assign ld_resp_data     = r_ld_resp_data;
  assign st_done          = r_st_done;
  assign err              = r_err;

endmodule

// File: tb/tb_mem_bus_scheduler.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_scheduler
//
// Directed bench for mem_bus_scheduler. Stimulus pushes the expected bus
// commands, load returns and store completions into queues; a monitor on the
// falling edge pops and compares whenever the DUT presents one of them.
// A small memory model (auto mode) assigns tags and returns every accepted
// command one cycle later; otherwise the memory inputs are driven directly.
// -----------------------------------------------------------------------------
module tb_mem_bus_scheduler;

  localparam int ADDR_W  = 64;
  localparam int DATA_W  = 64;
  localparam int TAG_W   = 4;
  localparam int MAX_OUT = 4;
  localparam int STARVE  = 4;

  localparam logic [1:0]  C_LD     = 2'd1;
  localparam logic [1:0]  C_ST     = 2'd2;
  localparam logic [63:0] AUTO_KEY = 64'hA5A5_0000_0000_5A5A;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // ---------------------------------------------------------------------------
  // DUT signals
  // ---------------------------------------------------------------------------
  logic              ld_req_valid;
  logic [ADDR_W-1:0] ld_req_addr;
  logic              ld_req_ready;
  logic              st_req_valid;
  logic [ADDR_W-1:0] st_req_addr;
  logic [DATA_W-1:0] st_req_data;
  logic              st_req_ready;
  logic              ld_resp_valid;
  logic [ADDR_W-1:0] ld_resp_addr;
  logic [DATA_W-1:0] ld_resp_data;
  logic              st_done;
  logic [1:0]        proc2mem_command;
  logic [ADDR_W-1:0] proc2mem_address;
  logic [DATA_W-1:0] proc2mem_data;
  logic [TAG_W-1:0]  mem2proc_response;
  logic [DATA_W-1:0] mem2proc_data;
  logic [TAG_W-1:0]  mem2proc_tag;
  logic              err;

  mem_bus_scheduler #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TAG_W  (TAG_W),
    .MAX_OUT(MAX_OUT),
    .STARVE (STARVE)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .ld_req_valid     (ld_req_valid),
    .ld_req_addr      (ld_req_addr),
    .ld_req_ready     (ld_req_ready),
    .st_req_valid     (st_req_valid),
    .st_req_addr      (st_req_addr),
    .st_req_data      (st_req_data),
    .st_req_ready     (st_req_ready),
    .ld_resp_valid    (ld_resp_valid),
    .ld_resp_addr     (ld_resp_addr),
    .ld_resp_data     (ld_resp_data),
    .st_done          (st_done),
    .proc2mem_command (proc2mem_command),
    .proc2mem_address (proc2mem_address),
    .proc2mem_data    (proc2mem_data),
    .mem2proc_response(mem2proc_response),
    .mem2proc_data    (mem2proc_data),
    .mem2proc_tag     (mem2proc_tag),
    .err              (err)
  );

  // ---------------------------------------------------------------------------
  // Memory side: manual values or auto model
  // ---------------------------------------------------------------------------
  logic              auto_mode = 1'b0;
  logic [TAG_W-1:0]  auto_tag;
  logic [TAG_W-1:0]  auto_ret_tag;
  logic [ADDR_W-1:0] auto_ret_addr;
  logic [TAG_W-1:0]  man_resp = '0;
  logic [TAG_W-1:0]  man_tag  = '0;
  logic [DATA_W-1:0] man_data = '0;

  always_comb begin
    if (auto_mode) begin
      mem2proc_response = (proc2mem_command != 2'd0) ? auto_tag : '0;
      mem2proc_tag      = auto_ret_tag;
      mem2proc_data     = (auto_ret_tag != '0) ? (auto_ret_addr ^ AUTO_KEY) : '0;
    end else begin
      mem2proc_response = man_resp;
      mem2proc_tag      = man_tag;
      mem2proc_data     = man_data;
    end
  end

  always @(posedge clock) begin
    if (!auto_mode) begin
      auto_tag      <= 4'd1;
      auto_ret_tag  <= '0;
      auto_ret_addr <= '0;
    end else if ((proc2mem_command != 2'd0) && (mem2proc_response != '0)) begin
      auto_ret_tag  <= auto_tag;
      auto_ret_addr <= proc2mem_address;
      auto_tag      <= (auto_tag == 4'd15) ? 4'd1 : auto_tag + 4'd1;
    end else begin
      auto_ret_tag  <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [129:0] exp_bus_q[$];
  logic [127:0] exp_ld_q[$];
  logic [0:0]   exp_st_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [129:0] act, input logic [129:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {129'b0, act}, {129'b0, exp});
  endtask

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk(name, {66'b0, act}, {66'b0, exp});
  endtask

  task automatic unexpected(input string name, input logic [127:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got unexpected %h, expected nothing", name, act);
  endtask

  task automatic push_bus(input logic [1:0] c, input logic [63:0] a, input logic [63:0] d);
    exp_bus_q.push_back({c, a, d});
  endtask

  task automatic push_ld(input logic [63:0] a, input logic [63:0] d);
    exp_ld_q.push_back({a, d});
  endtask

  // Monitor: sample away from the active edge.
  always @(negedge clock) begin
    if (!reset) begin
      if (proc2mem_command != 2'd0) begin
        if (exp_bus_q.size() == 0) begin
          unexpected("bus_cmd", {62'b0, proc2mem_command, proc2mem_address});
        end else begin
          chk("bus_cmd", {proc2mem_command, proc2mem_address, proc2mem_data}, exp_bus_q[0]);
          if (mem2proc_response != '0) void'(exp_bus_q.pop_front());
        end
      end
      if (ld_resp_valid) begin
        if (exp_ld_q.size() == 0) begin
          unexpected("ld_resp", {ld_resp_addr, ld_resp_data});
        end else begin
          chk("ld_resp", {2'b0, ld_resp_addr, ld_resp_data}, {2'b0, exp_ld_q[0]});
          void'(exp_ld_q.pop_front());
        end
      end
      if (st_done) begin
        if (exp_st_q.size() == 0) begin
          unexpected("st_done", 128'd1);
        end else begin
          chk1("st_done", st_done, exp_st_q[0]);
          void'(exp_st_q.pop_front());
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drv(input logic ldv, input logic [63:0] lda,
                     input logic stv, input logic [63:0] sta, input logic [63:0] std,
                     input logic [3:0] rsp, input logic [3:0] tg, input logic [63:0] md);
    ld_req_valid = ldv;
    ld_req_addr  = lda;
    st_req_valid = stv;
    st_req_addr  = sta;
    st_req_data  = std;
    man_resp     = rsp;
    man_tag      = tg;
    man_data     = md;
  endtask

  task automatic idle();
    drv(1'b0, 64'h0, 1'b0, 64'h0, 64'h0, 4'd0, 4'd0, 64'h0);
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  // Watchdog: the timeline is fixed-length, this only guards against a hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [63:0] st_a;
    logic [63:0] st_d;
    logic [63:0] ld_a;
    logic [1:0]  exp_g;
    int          si;
    int          li;

    idle();
    reset = 1'b1;
    nxt();
    nxt();

    // Reset state
    mid();
    chk64("rst_cmd",   {62'b0, proc2mem_command}, 64'd0);
    chk64("rst_addr",  proc2mem_address, 64'd0);
    chk64("rst_data",  proc2mem_data, 64'd0);
    chk1 ("rst_ldv",   ld_resp_valid, 1'b0);
    chk64("rst_ldaddr", ld_resp_addr, 64'd0);
    chk64("rst_lddata", ld_resp_data, 64'd0);
    chk1 ("rst_std",   st_done, 1'b0);
    chk1 ("rst_err",   err, 1'b0);
    chk1 ("rst_ldrdy", ld_req_ready, 1'b0);
    chk1 ("rst_strdy", st_req_ready, 1'b0);
    nxt();
    reset = 1'b0;

    // Single load 0x40, response tag 3, completion two cycles later
    drv(1'b1, 64'h40, 1'b0, 64'h0, 64'h0, 4'd0, 4'd0, 64'h0);
    mid(); chk1("t1_ldrdy", ld_req_ready, 1'b1); push_bus(C_LD, 64'h40, 64'h0);
    nxt();
    drv(1'b0, 64'h0, 1'b0, 64'h0, 64'h0, 4'd3, 4'd0, 64'h0);
    nxt();
    idle();
    nxt();
    drv(1'b0, 64'h0, 1'b0, 64'h0, 64'h0, 4'd0, 4'd3, 64'hDEAD_BEEF);
    mid(); push_ld(64'h40, 64'hDEAD_BEEF);
    nxt();
    idle();
    mid(); chk1("t1_err", err, 1'b0);
    nxt();

    // Reject/replay: STORE 0x80 data 5 rejected 3 times, then tag 2
    drv(1'b0, 64'h0, 1'b1, 64'h80, 64'h5, 4'd0, 4'd0, 64'h0);
    mid(); chk1("t2_strdy", st_req_ready, 1'b1); push_bus(C_ST, 64'h80, 64'h5);
    nxt();
    idle();
    nxt();
    drv(1'b1, 64'h99, 1'b0, 64'h0, 64'h0, 4'd0, 4'd0, 64'h0);
    mid(); chk1("t2_held_ldrdy", ld_req_ready, 1'b0);
    nxt();
    idle();
    nxt();
    drv(1'b0, 64'h0, 1'b0, 64'h0, 64'h0, 4'd2, 4'd0, 64'h0);
    nxt();
    idle();
    mid(); chk64("t2_bus_idle", {62'b0, proc2mem_command}, 64'd0);
    nxt();
    drv(1'b0, 64'h0, 1'b0, 64'h0, 64'h0, 4'd0, 4'd2, 64'h0);
    mid(); exp_st_q.push_back(1'b1);
    nxt();
    idle();
    nxt();

    // Tag reuse: load gets tag 5; store gets tag 5 in the cycle the load retires
    drv(1'b1, 64'h100, 1'b0, 64'h0, 64'h0, 4'd0, 4'd0, 64'h0);
    mid(); chk1("t3_ldrdy", ld_req_ready, 1'b1); push_bus(C_LD, 64'h100, 64'h0);
    nxt();
    drv(1'b0, 64'h0, 1'b1, 64'h200, 64'h77, 4'd5, 4'd0, 64'h0);
    mid(); chk1("t3_strdy", st_req_ready, 1'b1); push_bus(C_ST, 64'h200, 64'h77);
    nxt();
    drv(1'b0, 64'h0, 1'b0, 64'h0, 64'h0, 4'd5, 4'd5, 64'h1234);
    mid(); push_ld(64'h100, 64'h1234);
    nxt();
    idle();
    mid(); chk1("t3_err_reuse", err, 1'b0);
    nxt();
    drv(1'b0, 64'h0, 1'b0, 64'h0, 64'h0, 4'd0, 4'd5, 64'h0);
    mid(); exp_st_q.push_back(1'b1);
    nxt();
    idle();
    mid(); chk1("t3_err_after", err, 1'b0);
    nxt();

    // Capacity: four loads with tags held back, then one return frees a slot
    drv(1'b1, 64'h1000, 1'b0, 64'h0, 64'h0, 4'd0, 4'd0, 64'h0);
    mid(); chk1("t4_rdy0", ld_req_ready, 1'b1); push_bus(C_LD, 64'h1000, 64'h0);
    nxt();
    drv(1'b1, 64'h1008, 1'b0, 64'h0, 64'h0, 4'd1, 4'd0, 64'h0);
    mid(); chk1("t4_rdy1", ld_req_ready, 1'b1); push_bus(C_LD, 64'h1008, 64'h0);
    nxt();
    drv(1'b1, 64'h1010, 1'b0, 64'h0, 64'h0, 4'd2, 4'd0, 64'h0);
    mid(); chk1("t4_rdy2", ld_req_ready, 1'b1); push_bus(C_LD, 64'h1010, 64'h0);
    nxt();
    drv(1'b1, 64'h1018, 1'b0, 64'h0, 64'h0, 4'd3, 4'd0, 64'h0);
    mid(); chk1("t4_rdy3", ld_req_ready, 1'b1); push_bus(C_LD, 64'h1018, 64'h0);
    nxt();
    drv(1'b1, 64'h1020, 1'b0, 64'h0, 64'h0, 4'd4, 4'd0, 64'h0);
    mid(); chk1("t4_full_ldrdy", ld_req_ready, 1'b0);
    nxt();
    drv(1'b1, 64'h1020, 1'b1, 64'h4000, 64'hC, 4'd0, 4'd0, 64'h0);
    mid();
    chk1("t4_full2_ldrdy", ld_req_ready, 1'b0);
    chk1("t4_full2_strdy", st_req_ready, 1'b0);
    nxt();
    drv(1'b1, 64'h1020, 1'b1, 64'h4000, 64'hC, 4'd0, 4'd1, 64'h11);
    mid();
    chk1("t4_ret_ldrdy", ld_req_ready, 1'b0);
    chk1("t4_ret_strdy", st_req_ready, 1'b0);
    push_ld(64'h1000, 64'h11);
    nxt();
    drv(1'b1, 64'h1020, 1'b1, 64'h4000, 64'hC, 4'd0, 4'd0, 64'h0);
    mid();
    chk1("t4_after_strdy", st_req_ready, 1'b1);
    chk1("t4_after_ldrdy", ld_req_ready, 1'b0);
    push_bus(C_ST, 64'h4000, 64'hC);
    nxt();
    drv(1'b0, 64'h0, 1'b0, 64'h0, 64'h0, 4'd6, 4'd0, 64'h0);
    nxt();
    drv(1'b0, 64'h0, 1'b0, 64'h0, 64'h0, 4'd0, 4'd2, 64'h22);
    mid(); push_ld(64'h1008, 64'h22);
    nxt();
    drv(1'b0, 64'h0, 1'b0, 64'h0, 64'h0, 4'd0, 4'd3, 64'h33);
    mid(); push_ld(64'h1010, 64'h33);
    nxt();
    drv(1'b0, 64'h0, 1'b0, 64'h0, 64'h0, 4'd0, 4'd4, 64'h44);
    mid(); push_ld(64'h1018, 64'h44);
    nxt();
    drv(1'b0, 64'h0, 1'b0, 64'h0, 64'h0, 4'd0, 4'd6, 64'h0);
    mid(); exp_st_q.push_back(1'b1);
    nxt();
    idle();
    mid(); chk1("t4_err", err, 1'b0);
    nxt();

    // Starvation: both request streams always valid, memory always accepts
    auto_mode = 1'b1;
    si = 0;
    li = 0;
    for (int g = 0; g < 16; g++) begin
      st_a = 64'h2000 + 64'(si) * 64'd8;
      st_d = 64'h5000 + 64'(si);
      ld_a = 64'h3000 + 64'(li) * 64'd8;
      drv(1'b1, ld_a, 1'b1, st_a, st_d, 4'd0, 4'd0, 64'h0);
      mid();
      exp_g = ((g % 4) == 3) ? 2'b01 : 2'b10;
      chk64("t5_grant", {62'b0, st_req_ready, ld_req_ready}, {62'b0, exp_g});
      if (st_req_ready) begin
        push_bus(C_ST, st_a, st_d);
        exp_st_q.push_back(1'b1);
        si++;
      end
      if (ld_req_ready) begin
        push_bus(C_LD, ld_a, 64'h0);
        push_ld(ld_a, ld_a ^ AUTO_KEY);
        li++;
      end
      nxt();
    end
    idle();
    repeat (4) nxt();
    auto_mode = 1'b0;
    mid(); chk1("t5_err", err, 1'b0);
    nxt();

    // Unknown tag sets err
    drv(1'b0, 64'h0, 1'b0, 64'h0, 64'h0, 4'd0, 4'd7, 64'h0);
    mid(); chk1("t6_err_before", err, 1'b0);
    nxt();
    idle();
    mid(); chk1("t6_err_set", err, 1'b1);
    nxt();

    // Reset with two entries outstanding and a command on the bus
    drv(1'b1, 64'h500, 1'b0, 64'h0, 64'h0, 4'd0, 4'd0, 64'h0);
    mid(); chk1("t7_rdy0", ld_req_ready, 1'b1); push_bus(C_LD, 64'h500, 64'h0);
    nxt();
    drv(1'b1, 64'h508, 1'b0, 64'h0, 64'h0, 4'd1, 4'd0, 64'h0);
    mid(); chk1("t7_rdy1", ld_req_ready, 1'b1); push_bus(C_LD, 64'h508, 64'h0);
    nxt();
    // This third grant is discarded by the reset below.
    drv(1'b1, 64'h510, 1'b0, 64'h0, 64'h0, 4'd2, 4'd0, 64'h0);
    mid(); chk1("t7_rdy2", ld_req_ready, 1'b1);
    nxt();
    idle();
    reset = 1'b1;
    nxt();
    mid();
    chk64("t7_rst_cmd", {62'b0, proc2mem_command}, 64'd0);
    chk1 ("t7_rst_ldv", ld_resp_valid, 1'b0);
    chk1 ("t7_rst_std", st_done, 1'b0);
    chk1 ("t7_rst_err", err, 1'b0);
    nxt();
    reset = 1'b0;
    drv(1'b0, 64'h0, 1'b0, 64'h0, 64'h0, 4'd0, 4'd1, 64'hAA);
    nxt();
    drv(1'b0, 64'h0, 1'b0, 64'h0, 64'h0, 4'd0, 4'd2, 64'hBB);
    mid(); chk1("t7_stale_err", err, 1'b1);
    nxt();
    idle();
    mid();
    chk1("t7_stale_ldv", ld_resp_valid, 1'b0);
    chk1("t7_stale_std", st_done, 1'b0);
    chk1("t7_err_hold", err, 1'b1);
    nxt();
    nxt();

    // Every expected item must have been seen
    chk64("bus_q_empty", 64'(exp_bus_q.size()), 64'd0);
    chk64("ld_q_empty",  64'(exp_ld_q.size()), 64'd0);
    chk64("st_q_empty",  64'(exp_st_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
